// File: rtl/control_pkg.sv
// Shared types and encodings for the multicycle control unit.
// Holds the FSM state enum, opcode values and datapath mux/ALU select codes.
package control_pkg;

    typedef enum logic [3:0] {
        RESET_S   = 4'd0,
        FETCH     = 4'd1,
        DECODE    = 4'd2,
        MEM_ADDR  = 4'd3,
        MEM_READ  = 4'd4,
        MEM_WB    = 4'd5,
        MEM_WRITE = 4'd6,
        EXECUTE   = 4'd7,
        ALU_WB    = 4'd8,
        BRANCH    = 4'd9,
        JUMP      = 4'd10,
        TRAP      = 4'd11
    } state_t;

    typedef enum logic [2:0] {
        CLS_RTYPE   = 3'd0,
        CLS_LW      = 3'd1,
        CLS_SW      = 3'd2,
        CLS_BEQ     = 3'd3,
        CLS_J       = 3'd4,
        CLS_ILLEGAL = 3'd5
    } instr_class_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_write;
        logic       reg_dst;
        logic       alu_src_a;
        logic [1:0] alu_op;
        logic [1:0] alu_src_b;
        logic [1:0] pc_source;
    } ctrl_t;

    function automatic state_t state_after_decode(input instr_class_t cls);
        state_t nxt;
        case (cls)
            CLS_RTYPE: nxt = EXECUTE;
            CLS_LW:    nxt = MEM_ADDR;
            CLS_SW:    nxt = MEM_ADDR;
            CLS_BEQ:   nxt = BRANCH;
            CLS_J:     nxt = JUMP;
            default:   nxt = TRAP;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/opcode_decoder.sv
// Combinational opcode-to-instruction-class decode with an illegal indication.
module opcode_decoder
    import control_pkg::*;
(
    input  logic [5:0]   i_opcode,
    output instr_class_t o_class,
    output logic         o_illegal
);

    always_comb begin
        o_class   = CLS_ILLEGAL;
        o_illegal = 1'b0;
        case (i_opcode)
            OP_RTYPE: o_class = CLS_RTYPE;
            OP_LW:    o_class = CLS_LW;
            OP_SW:    o_class = CLS_SW;
            OP_BEQ:   o_class = CLS_BEQ;
            OP_J:     o_class = CLS_J;
            default: begin
                o_class   = CLS_ILLEGAL;
                o_illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle MIPS-style control FSM: registered state and sticky illegal flag,
// combinational control outputs decoded from the current state.
module multicycle_control_unit
    import control_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       alu_src_a,
    output logic [1:0] alu_op,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_source,
    output logic       illegal_op,
    output logic [3:0] state
);

    state_t       r_state;
    logic         r_illegal;
    logic         r_is_store;
    instr_class_t w_class;
    logic         w_illegal;
    ctrl_t        w_ctrl;

    opcode_decoder u_opcode_decoder (
        .i_opcode  (opcode),
        .o_class   (w_class),
        .o_illegal (w_illegal)
    );

    // LW/SW choice is latched in DECODE so opcode is never looked at afterwards
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= RESET_S;
            r_illegal  <= 1'b0;
            r_is_store <= 1'b0;
        end else begin
            case (r_state)
                RESET_S:   r_state <= FETCH;
                FETCH:     if (mem_ready) r_state <= DECODE;
                DECODE: begin
                    r_state    <= state_after_decode(w_class);
                    r_is_store <= (w_class == CLS_SW);
                    if (w_illegal) r_illegal <= 1'b1;
                end
                MEM_ADDR:  r_state <= r_is_store ? MEM_WRITE : MEM_READ;
                MEM_READ:  if (mem_ready) r_state <= MEM_WB;
                MEM_WB:    r_state <= FETCH;
                MEM_WRITE: if (mem_ready) r_state <= FETCH;
                EXECUTE:   r_state <= ALU_WB;
                ALU_WB:    r_state <= FETCH;
                BRANCH:    r_state <= FETCH;
                JUMP:      r_state <= FETCH;
                TRAP:      r_state <= TRAP;
                default:   r_state <= RESET_S;
            endcase
        end
    end

    always_comb begin
        w_ctrl = '0;
        case (r_state)
            FETCH: begin
                w_ctrl.mem_read  = 1'b1;
                w_ctrl.alu_src_b = SRCB_FOUR;
                w_ctrl.alu_op    = ALU_ADD;
                w_ctrl.ir_write  = mem_ready;
                w_ctrl.pc_write  = mem_ready;
            end
            DECODE: begin
                w_ctrl.alu_src_b = SRCB_IMM_SH;
                w_ctrl.alu_op    = ALU_ADD;
            end
            MEM_ADDR: begin
                w_ctrl.alu_src_a = 1'b1;
                w_ctrl.alu_src_b = SRCB_IMM;
                w_ctrl.alu_op    = ALU_ADD;
            end
            MEM_READ: begin
                w_ctrl.mem_read = 1'b1;
                w_ctrl.i_or_d   = 1'b1;
            end
            MEM_WB: begin
                w_ctrl.reg_write  = 1'b1;
                w_ctrl.mem_to_reg = 1'b1;
                w_ctrl.reg_dst    = 1'b0;
            end
            MEM_WRITE: begin
                w_ctrl.mem_write = 1'b1;
                w_ctrl.i_or_d    = 1'b1;
            end
            EXECUTE: begin
                w_ctrl.alu_src_a = 1'b1;
                w_ctrl.alu_src_b = SRCB_REG;
                w_ctrl.alu_op    = ALU_FUNCT;
            end
            ALU_WB: begin
                w_ctrl.reg_write = 1'b1;
                w_ctrl.reg_dst   = 1'b1;
            end
            BRANCH: begin
                w_ctrl.alu_src_a     = 1'b1;
                w_ctrl.alu_op        = ALU_SUB;
                w_ctrl.pc_write_cond = 1'b1;
                w_ctrl.pc_source     = PCSRC_ALUOUT;
            end
            JUMP: begin
                w_ctrl.pc_write  = 1'b1;
                w_ctrl.pc_source = PCSRC_JUMP;
            end
            default: w_ctrl = '0;
        endcase
    end

    assign pc_write      = w_ctrl.pc_write;
    assign pc_write_cond = w_ctrl.pc_write_cond;
    assign i_or_d        = w_ctrl.i_or_d;
    assign mem_read      = w_ctrl.mem_read;
    assign mem_write     = w_ctrl.mem_write;
    assign ir_write      = w_ctrl.ir_write;
    assign mem_to_reg    = w_ctrl.mem_to_reg;
    assign reg_write     = w_ctrl.reg_write;
    assign reg_dst       = w_ctrl.reg_dst;
    assign alu_src_a     = w_ctrl.alu_src_a;
    assign alu_op        = w_ctrl.alu_op;
    assign alu_src_b     = w_ctrl.alu_src_b;
    assign pc_source     = w_ctrl.pc_source;
    assign illegal_op    = r_illegal;
    assign state         = r_state;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Table-driven bench for multicycle_control_unit plus an async-reset sequence.
module tb_multicycle_control_unit;
    import control_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] opcode = 6'b0;
    logic       mem_ready = 1'b0;
    logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_write, reg_dst, alu_src_a, illegal_op;
    logic [1:0] alu_op, alu_src_b, pc_source;
    logic [3:0] state;

    int checks = 0;
    int failures = 0;

    multicycle_control_unit dut (
        .clk           (clk),
        .rst           (rst),
        .opcode        (opcode),
        .mem_ready     (mem_ready),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .i_or_d        (i_or_d),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .mem_to_reg    (mem_to_reg),
        .reg_write     (reg_write),
        .reg_dst       (reg_dst),
        .alu_src_a     (alu_src_a),
        .alu_op        (alu_op),
        .alu_src_b     (alu_src_b),
        .pc_source     (pc_source),
        .illegal_op    (illegal_op),
        .state         (state)
    );

    always #5 clk = ~clk;

    // {pcw,pcwc,iord,mr,mw,irw,m2r,rw,rd,asa}_{alu_op}_{src_b}_{pc_src}_{illegal}
    logic [16:0] act;
    assign act = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                  mem_to_reg, reg_write, reg_dst, alu_src_a, alu_op, alu_src_b,
                  pc_source, illegal_op};

    localparam logic [16:0] E_ZERO   = 17'b0000000000_00_00_00_0;
    localparam logic [16:0] E_FRDY   = 17'b1001010000_00_01_00_0;
    localparam logic [16:0] E_FWAIT  = 17'b0001000000_00_01_00_0;
    localparam logic [16:0] E_DEC    = 17'b0000000000_00_11_00_0;
    localparam logic [16:0] E_MADDR  = 17'b0000000001_00_10_00_0;
    localparam logic [16:0] E_MREAD  = 17'b0011000000_00_00_00_0;
    localparam logic [16:0] E_MWB    = 17'b0000001100_00_00_00_0;
    localparam logic [16:0] E_MWRITE = 17'b0010100000_00_00_00_0;
    localparam logic [16:0] E_EXEC   = 17'b0000000001_10_00_00_0;
    localparam logic [16:0] E_ALUWB  = 17'b0000000110_00_00_00_0;
    localparam logic [16:0] E_BRANCH = 17'b0100000001_01_00_01_0;
    localparam logic [16:0] E_JUMP   = 17'b1000000000_00_00_10_0;
    localparam logic [16:0] E_TRAP   = 17'b0000000000_00_00_00_1;

    localparam logic [5:0] O_R = 6'b000000, O_LW = 6'b100011, O_SW = 6'b101011;
    localparam logic [5:0] O_BEQ = 6'b000100, O_J = 6'b000010, O_BAD = 6'b111111;

    typedef struct {
        logic        rst;
        logic [5:0]  op;
        logic        rdy;
        logic [3:0]  st;
        logic [16:0] ctl;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic [5:0] op, input logic rdy,
                       input logic [3:0] st, input logic [16:0] ctl);
        vec_t v;
        v.rst = r; v.op = op; v.rdy = rdy; v.st = st; v.ctl = ctl;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int idx, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s step=%0d got=%0h expected=%0h", name, idx, got, exp);
        end
    endtask

    initial begin
        // LW, zero wait states
        add(1, O_LW, 1, RESET_S, E_ZERO);
        add(0, O_LW, 1, RESET_S, E_ZERO);
        add(0, O_LW, 1, FETCH, E_FRDY);
        add(0, O_LW, 1, DECODE, E_DEC);
        add(0, O_LW, 1, MEM_ADDR, E_MADDR);
        add(0, O_LW, 1, MEM_READ, E_MREAD);
        add(0, O_LW, 1, MEM_WB, E_MWB);
        // SW with two wait cycles; opcode changes after DECODE must be ignored
        add(0, O_SW, 1, FETCH, E_FRDY);
        add(0, O_SW, 1, DECODE, E_DEC);
        add(0, O_LW, 1, MEM_ADDR, E_MADDR);
        add(0, O_LW, 0, MEM_WRITE, E_MWRITE);
        add(0, O_BAD, 0, MEM_WRITE, E_MWRITE);
        add(0, O_SW, 1, MEM_WRITE, E_MWRITE);
        // R-type then BEQ
        add(0, O_R, 1, FETCH, E_FRDY);
        add(0, O_R, 1, DECODE, E_DEC);
        add(0, O_R, 1, EXECUTE, E_EXEC);
        add(0, O_R, 1, ALU_WB, E_ALUWB);
        add(0, O_BEQ, 1, FETCH, E_FRDY);
        add(0, O_BEQ, 1, DECODE, E_DEC);
        add(0, O_BEQ, 1, BRANCH, E_BRANCH);
        // fetch stall of three cycles, then J
        add(0, O_J, 0, FETCH, E_FWAIT);
        add(0, O_J, 0, FETCH, E_FWAIT);
        add(0, O_J, 0, FETCH, E_FWAIT);
        add(0, O_J, 1, FETCH, E_FRDY);
        add(0, O_J, 1, DECODE, E_DEC);
        add(0, O_J, 1, JUMP, E_JUMP);
        // illegal opcode traps until reset
        add(0, O_BAD, 1, FETCH, E_FRDY);
        add(0, O_BAD, 1, DECODE, E_DEC);
        add(0, O_BAD, 1, TRAP, E_TRAP);
        add(0, O_LW, 0, TRAP, E_TRAP);
        add(0, O_R, 1, TRAP, E_TRAP);
        add(1, O_R, 1, RESET_S, E_ZERO);
        add(0, O_R, 1, RESET_S, E_ZERO);
        add(0, O_LW, 1, FETCH, E_FRDY);

        foreach (vecs[i]) begin
            @(negedge clk);
            rst = vecs[i].rst;
            opcode = vecs[i].op;
            mem_ready = vecs[i].rdy;
            #1;
            chk("state", i, 32'(state), 32'(vecs[i].st));
            chk("ctrl", i, 32'(act), 32'(vecs[i].ctl));
        end

        // LW stalled in MEM_READ, then async reset between clock edges
        @(negedge clk); opcode = O_LW; mem_ready = 1'b1; #1;
        chk("seq_decode", 100, 32'(state), 32'(DECODE));
        @(negedge clk); #1;
        chk("seq_maddr", 101, 32'(state), 32'(MEM_ADDR));
        @(negedge clk); mem_ready = 1'b0; #1;
        chk("seq_mread_state", 102, 32'(state), 32'(MEM_READ));
        chk("seq_mread_rd", 103, 32'(mem_read), 32'd1);
        @(posedge clk); #3; rst = 1'b1; #1;
        chk("async_rst_state", 104, 32'(state), 32'(RESET_S));
        chk("async_rst_ctrl", 105, 32'(act), 32'(E_ZERO));
        @(posedge clk); #1;
        chk("rst_hold_ctrl", 106, 32'(act), 32'(E_ZERO));
        @(negedge clk); rst = 1'b0; #1;
        chk("rst_release", 107, 32'(state), 32'(RESET_S));
        @(posedge clk); #1;
        chk("fetch_after_rst", 108, 32'(state), 32'(FETCH));
        chk("fetch_wait_ctrl", 109, 32'(act), 32'(E_FWAIT));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout got=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
